// File: rtl/shift_univ_if.sv
// Bus bundle for shift_univ_reg: control/data toward the register, contents/status back.
// Carries the rot input only when SHIFT_ROTATE_EN is defined.
interface shift_univ_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             shift_en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] par_in;
  logic             serial_in;
`ifdef SHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] par_out;
  logic             serial_out;
  logic [CNT_W-1:0] shift_cnt;
  logic             frame_done;

`ifdef SHIFT_ROTATE_EN
  modport master (
    output shift_en, dir, load, par_in, serial_in, rot,
    input  par_out, serial_out, shift_cnt, frame_done
  );
  modport slave (
    input  shift_en, dir, load, par_in, serial_in, rot,
    output par_out, serial_out, shift_cnt, frame_done
  );
`else
  modport master (
    output shift_en, dir, load, par_in, serial_in,
    input  par_out, serial_out, shift_cnt, frame_done
  );
  modport slave (
    input  shift_en, dir, load, par_in, serial_in,
    output par_out, serial_out, shift_cnt, frame_done
  );
`endif
endinterface

// File: rtl/shift_univ_reg.sv
// Universal bidirectional shift register with bit-slot counter and frame-done pulse.
// Optional feature: SHIFT_ROTATE_EN adds a rot input that recirculates the outgoing bit.
module shift_univ_reg #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic        clk,
  input logic        rst,
  shift_univ_if.slave bus
);
  localparam int unsigned      CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q, q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fd, fd_nxt;
  logic             out_bit;
  logic             in_bit;

  // Bit leaving the register on the next shift in the current direction
  assign out_bit = bus.dir ? q[WIDTH-1] : q[0];

`ifdef SHIFT_ROTATE_EN
  assign in_bit = bus.rot ? out_bit : bus.serial_in;
`else
  assign in_bit = bus.serial_in;
`endif

  // Next-state: load beats shift, hold clears the frame pulse
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    fd_nxt  = 1'b0;
    if (bus.load) begin
      q_nxt   = bus.par_in;
      cnt_nxt = '0;
    end else if (bus.shift_en) begin
      q_nxt = bus.dir ? {q[WIDTH-2:0], in_bit} : {in_bit, q[WIDTH-1:1]};
      if (cnt == CNT_MAX) begin
        cnt_nxt = '0;
        fd_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= RESET_VAL;
      cnt <= '0;
      fd  <= 1'b0;
    end else begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
      fd  <= fd_nxt;
    end
  end

  assign bus.par_out    = q;
  assign bus.serial_out = out_bit;
  assign bus.shift_cnt  = cnt;
  assign bus.frame_done = fd;
endmodule

// File: tb/tb_shift_univ_reg.sv
// Testbench for shift_univ_reg (WIDTH=8): directed scenarios plus random traffic vs. an arithmetic model.
module tb_shift_univ_reg;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model: register as a number, frame position from total shifts
  logic [W-1:0] mq;
  int           mshifts;
  logic         mfd;

  shift_univ_if #(.WIDTH(W)) bus ();
  shift_univ_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic ld, input logic [W-1:0] pi,
                            input logic se, input logic d, input logic si, input logic ro);
    logic ob, ib;
    if (!r) begin
      mq = 8'h00; mshifts = 0; mfd = 1'b0;
    end else if (ld) begin
      mq = pi; mshifts = 0; mfd = 1'b0;
    end else if (se) begin
      ob = d ? mq[W-1] : mq[0];
      ib = ro ? ob : si;
      if (d) mq = W'((32'(mq) * 2 + 32'(ib)) % 256);
      else   mq = W'(32'(mq) / 2 + 32'(ib) * 128);
      mshifts++;
      mfd = (mshifts % W == 0);
    end else begin
      mfd = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [W-1:0] pi,
                     input logic se, input logic d, input logic si, input logic ro);
    rst = r; bus.load = ld; bus.par_in = pi; bus.shift_en = se;
    bus.dir = d; bus.serial_in = si;
`ifdef SHIFT_ROTATE_EN
    bus.rot = ro;
`endif
    @(posedge clk);
    #1;
`ifdef SHIFT_ROTATE_EN
    model_step(r, ld, pi, se, d, si, ro);
`else
    model_step(r, ld, pi, se, d, si, 1'b0);
`endif
    chk("par_out", 32'(bus.par_out), 32'(mq));
    chk("serial_out", 32'(bus.serial_out), 32'(d ? mq[W-1] : mq[0]));
    chk("shift_cnt", 32'(bus.shift_cnt), 32'(mshifts % W));
    chk("frame_done", 32'(bus.frame_done), 32'(mfd));
  endtask

  initial begin
    logic [7:0] stream;
    int         pulses;
    mq = '0; mshifts = 0; mfd = 1'b0;
    rst = 1'b0; bus.load = 1'b0; bus.par_in = '0; bus.shift_en = 1'b0;
    bus.dir = 1'b0; bus.serial_in = 1'b0;
`ifdef SHIFT_ROTATE_EN
    bus.rot = 1'b0;
`endif
    #2;

    // Reset state, with load and shift requested at the same time
    cyc(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reset_par_out", 32'(bus.par_out), 32'h00);

    // SIPO/SISO right shift of 1,0,1,1,0,0,0,0
    stream = 8'b00001101;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, stream[i], 1'b0);
      if (i < 7) chk("s1_no_early_fd", 32'(bus.frame_done), 32'h0);
    end
    chk("s1_par_out", 32'(bus.par_out), 32'h0D);
    chk("s1_serial_out", 32'(bus.serial_out), 32'h1);
    chk("s1_frame_done", 32'(bus.frame_done), 32'h1);
    chk("s1_shift_cnt", 32'(bus.shift_cnt), 32'h0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_fd_one_cycle", 32'(bus.frame_done), 32'h0);

    // PISO left shift of A5; first bit visible straight after load
    cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("s2_first_bit", 32'(bus.serial_out), 32'h1);
    stream = 8'b10100101;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) chk("s2_seq", 32'(bus.serial_out), 32'(stream[7-i]));
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      if (bus.frame_done) pulses++;
    end
    chk("s2_par_out", 32'(bus.par_out), 32'h00);
    chk("s2_pulses", 32'(pulses), 32'h1);

    // Load wins over shift, then hold
    cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s3_par_out", 32'(bus.par_out), 32'h3C);
    chk("s3_shift_cnt", 32'(bus.shift_cnt), 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s3_hold", 32'(bus.par_out), 32'h3C);
    chk("s3_hold_fd", 32'(bus.frame_done), 32'h0);

    // Mid-frame reset discards the partial frame
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s4_par_out", 32'(bus.par_out), 32'h00);
    chk("s4_shift_cnt", 32'(bus.shift_cnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("s4_fd_at_8", 32'(bus.frame_done), 32'(i == 7));
    end

    // 16 continuous shifts with a direction change mid-frame
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'(i >= 5 && i < 11), 1'(i % 3 == 0), 1'b0);
      chk("s5_fd", 32'(bus.frame_done), 32'(i == 7 || i == 15));
      chk("s5_cnt", 32'(bus.shift_cnt), 32'((i + 1) % 8));
    end

`ifdef SHIFT_ROTATE_EN
    cyc(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s6_rot1", 32'(bus.par_out), 32'hC0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s6_rot8", 32'(bus.par_out), 32'h81);
`else
    cyc(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s6_no_rot", 32'(bus.par_out), 32'h00);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 7) == 0),
          8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
